// File: rtl/githubusername_top_template.sv
// Prescaled, loadable up/down decimal counter driving a seven-segment display.
// io_i packs {data[3:0], dir, load, rst, clk}; io_o packs {dp, g..a}.
module githubusername_top_template #(
  parameter int PRESCALE = 1
) (
  input  logic [7:0] io_i,
  output logic [7:0] io_o
);

  localparam int            PW         = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  logic          clk_s;
  logic          rst_s;
  logic          load_s;
  logic          dir_s;
  logic [3:0]    data_s;
  logic          tick_s;

  logic [3:0]    digit_q, digit_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          wrap_q,  wrap_d;

  assign clk_s  = io_i[0];
  assign rst_s  = io_i[1];
  assign load_s = io_i[2];
  assign dir_s  = io_i[3];
  assign data_s = io_i[7:4];

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // State registers with asynchronous reset
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      digit_q <= 4'd0;
      presc_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      digit_q <= digit_d;
      presc_q <= presc_d;
      wrap_q  <= wrap_d;
    end
  end

  // Next-state logic: load wins over a tick, and a load restarts the prescale period
  always_comb begin
    tick_s  = (presc_q == PRESC_LAST);
    digit_d = digit_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    if (load_s) begin
      digit_d = (data_s > 4'd9) ? 4'd9 : data_s;
      presc_d = '0;
    end else begin
      if (tick_s) begin
        presc_d = '0;
        if (dir_s) begin
          digit_d = (digit_q >= 4'd9) ? 4'd0 : digit_q + 4'd1;
          wrap_d  = (digit_q >= 4'd9);
        end else begin
          digit_d = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
          wrap_d  = (digit_q == 4'd0);
        end
      end else begin
        presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
      end
    end
  end

  // Display decode straight from the registered digit
  always_comb begin
    io_o = {wrap_q, seg_decode(digit_q)};
  end

endmodule

// File: tb/tb_githubusername_top_template.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_githubusername_top_template;

  typedef struct {
    string      name;
    bit         sel4;
    logic [7:0] exp;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       load;
  logic       dir;
  logic [3:0] data;
  logic [7:0] io_i;
  logic [7:0] out1;
  logic [7:0] out4;

  exp_t exp_q[$];
  event push_ev;
  int   checks = 0;
  int   errors = 0;

  assign io_i = {data, dir, load, rst, clk};

  githubusername_top_template #(.PRESCALE(1)) dut1 (.io_i(io_i), .io_o(out1));
  githubusername_top_template #(.PRESCALE(4)) dut4 (.io_i(io_i), .io_o(out4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: drain every pending expectation against the selected DUT
  initial begin
    forever begin
      @(push_ev);
      while (exp_q.size() != 0) begin
        exp_t e;
        logic [7:0] act;
        e   = exp_q.pop_front();
        act = e.sel4 ? out4 : out1;
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  task automatic chk(input string name, input bit sel4, input logic [7:0] exp);
    exp_t e;
    e.name = name;
    e.sel4 = sel4;
    e.exp  = exp;
    exp_q.push_back(e);
    -> push_ev;
    #1;
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    dir  = 1'b0;
    data = 4'd0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      chk("rst_pos_p1", 1'b0, 8'h3F);
      chk("rst_pos_p4", 1'b1, 8'h3F);
      @(negedge clk);
      chk("rst_neg_p1", 1'b0, 8'h3F);
      chk("rst_neg_p4", 1'b1, 8'h3F);
    end

    // Up count, every edge a tick
    rst = 1'b0;
    dir = 1'b1;
    edges(1);  chk("up_1", 1'b0, 8'h06);
    edges(8);  chk("up_9", 1'b0, 8'h6F);
    edges(1);  chk("up_10_wrap", 1'b0, 8'hBF);
    edges(1);  chk("up_11", 1'b0, 8'h06);
    edges(4);  chk("up_to_5", 1'b0, 8'h6D);

    // Asynchronous reset mid-count, before the next edge
    rst = 1'b1;
    #1;
    chk("rst_async", 1'b0, 8'h3F);
    edges(1);  chk("rst_held", 1'b0, 8'h3F);

    // Down wrap from 0
    rst = 1'b0;
    dir = 1'b0;
    edges(1);  chk("down_wrap", 1'b0, 8'hEF);
    edges(1);  chk("down_8", 1'b0, 8'h7F);

    // Loads, saturation, load over wrap
    load = 1'b1; data = 4'd7;
    edges(1);  chk("load_7", 1'b0, 8'h07);
    data = 4'd12;
    edges(1);  chk("load_sat", 1'b0, 8'h6F);
    dir = 1'b1; data = 4'd3;
    edges(1);  chk("load_beats_wrap", 1'b0, 8'h4F);
    load = 1'b0;
    edges(1);  chk("after_load", 1'b0, 8'h66);

    // Prescale by 4
    rst = 1'b1;
    edges(1);
    rst = 1'b0;
    dir = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      edges(1); chk("pre_hold", 1'b1, 8'h3F);
    end
    edges(1);  chk("pre_edge4", 1'b1, 8'h06);
    edges(32); chk("pre_at_9", 1'b1, 8'h6F);
    for (int i = 1; i <= 3; i++) begin
      edges(1); chk("pre_9_hold", 1'b1, 8'h6F);
    end
    edges(1);  chk("pre_wrap_dp", 1'b1, 8'hBF);
    edges(1);  chk("pre_dp_clear", 1'b1, 8'h3F);
    edges(1);  chk("pre_mid", 1'b1, 8'h3F);
    load = 1'b1; data = 4'd5;
    edges(1);  chk("pre_load", 1'b1, 8'h6D);
    load = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      edges(1); chk("pre_restart_hold", 1'b1, 8'h6D);
    end
    edges(1);  chk("pre_restart_tick", 1'b1, 8'h7D);

    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
